data_mem_loader: RTL and testbench

Byte-stream loader that fills the data memory before or between program runs. It accepts bytes over a valid/ready handshake and packs each group of four into a 32-bit word, first byte most significant. Each word is written into the data memory at consecutive word-aligned addresses and then read back for verification. It sits directly upstream of the data memory, and owns the memory port while busy; the core's MEM-stage accesses are muxed through it.

---
 rtl/data_mem_loader_pkg.sv | 27 ++
 rtl/data_mem_loader_packer.sv | 30 +++
 rtl/data_mem_loader.sv | 147 ++++++++++++++
 tb/tb_data_mem_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_loader_pkg.sv
// Shared data-memory definitions and the loader state encoding.
// The data memory and the loader both take MEM_BASE from here.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef DATA_MEM_SIZE
`define DATA_MEM_SIZE 2048
`endif
`ifndef MEM_CELL_SIZE
`define MEM_CELL_SIZE 8
`endif

package data_mem_loader_pkg;
    localparam int WORD_BITS  = `WORD_LEN;
    localparam int MEM_BYTES  = `DATA_MEM_SIZE;
    localparam int CELL_BITS  = `MEM_CELL_SIZE;
    localparam int MEM_BASE   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_COLLECT,
        ST_WRITE,
        ST_VERIFY,
        ST_FINISH
    } loader_state_t;
endpackage

// File: rtl/data_mem_loader_packer.sv
// Packs accepted stream bytes into a word, first byte most significant.
// word_ready flags the handshake that completes the fourth byte.
module byte_packer
    import data_mem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 take,
    input  logic [7:0]           byte_in,
    output logic [`WORD_LEN-1:0] word,
    output logic                 word_ready
);
    logic [1:0] byte_idx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (take) begin
            word     <= {word[`WORD_LEN-9:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign word_ready = take && (byte_idx == 2'd3);
endmodule

// File: rtl/data_mem_loader.sv
// Streams bytes into the data memory word by word with read-back verification.
// Owns the memory port while busy; in IDLE the core's MEM-stage request passes through.
module data_mem_loader
    import data_mem_loader_pkg::*;
#(
    parameter int MEM_BASE = data_mem_loader_pkg::MEM_BASE,
    parameter int MEM_SIZE = `DATA_MEM_SIZE,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [`WORD_LEN-1:0] startAddr,
    input  logic [CNT_W-1:0]     wordCount,
    input  logic                 byteValid,
    input  logic [7:0]           byteData,
    output logic                 byteReady,
    input  logic                 coreReadEn,
    input  logic                 coreWriteEn,
    input  logic [`WORD_LEN-1:0] coreAddress,
    input  logic [`WORD_LEN-1:0] coreDataIn,
    output logic                 coreStall,
    output logic                 memReadEn,
    output logic                 memWriteEn,
    output logic [`WORD_LEN-1:0] memAddress,
    output logic [`WORD_LEN-1:0] memDataIn,
    input  logic [`WORD_LEN-1:0] memDataOut,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int WL = `WORD_LEN;
    localparam logic [WL-1:0]    ALIGN_MASK = 3;
    localparam logic [WL-1:0]    WORD_STEP  = 4;
    localparam logic [WL-1:0]    BASE_ADDR  = MEM_BASE;
    localparam logic [WL:0]      MEM_LIMIT  = MEM_SIZE;
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;

    loader_state_t    state;
    logic [WL-1:0]    cur_addr;
    logic [CNT_W-1:0] remaining;
    logic [WL-1:0]    word;
    logic             word_ready;
    logic             range_bad;
    logic [WL:0]      end_addr;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == ST_CHECK),
        .take       (byteValid && byteReady),
        .byte_in    (byteData),
        .word       (word),
        .word_ready (word_ready)
    );

    // One extra bit so a range ending past the top of the address space cannot wrap.
    assign end_addr  = {1'b0, cur_addr} + {{(WL-CNT_W-1){1'b0}}, remaining, 2'b00};
    assign range_bad = (cur_addr < BASE_ADDR) || (end_addr > MEM_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            byteReady <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    cur_addr  <= startAddr & ~ALIGN_MASK;
                    remaining <= wordCount;
                    error     <= 1'b0;
                    busy      <= 1'b1;
                    state     <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (range_bad || remaining == '0) begin
                        error <= range_bad;
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end else begin
                        byteReady <= 1'b1;
                        state     <= ST_COLLECT;
                    end
                end
                ST_COLLECT: if (word_ready) begin
                    byteReady <= 1'b0;
                    state     <= ST_WRITE;
                end
                ST_WRITE: state <= ST_VERIFY;
                ST_VERIFY: begin
                    if (memDataOut != word) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end else begin
                        cur_addr  <= cur_addr + WORD_STEP;
                        remaining <= remaining - CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            byteReady <= 1'b1;
                            state     <= ST_COLLECT;
                        end
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        memReadEn  = 1'b0;
        memWriteEn = 1'b0;
        memAddress = '0;
        memDataIn  = '0;
        coreStall  = (state != ST_IDLE) && (coreReadEn || coreWriteEn);
        case (state)
            ST_IDLE: begin
                memReadEn  = coreReadEn;
                memWriteEn = coreWriteEn;
                memAddress = coreAddress;
                memDataIn  = coreDataIn;
            end
            ST_WRITE: begin
                memWriteEn = 1'b1;
                memAddress = cur_addr;
                memDataIn  = word;
            end
            ST_VERIFY: begin
                memReadEn  = 1'b1;
                memAddress = cur_addr;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_data_mem_loader.sv
// Randomized self-checking bench for data_mem_loader against a word-level reference model.
module tb_data_mem_loader;
    import data_mem_loader_pkg::*;

    localparam int NW = MEM_BYTES / 4;
    localparam int IW = $clog2(NW);

    logic        clk = 1'b0;
    logic        rst, start, byteValid, byteReady;
    logic [31:0] startAddr;
    logic [15:0] wordCount;
    logic [7:0]  byteData;
    logic        coreReadEn, coreWriteEn, coreStall;
    logic [31:0] coreAddress, coreDataIn;
    logic        memReadEn, memWriteEn;
    logic [31:0] memAddress, memDataIn, memDataOut;
    logic        busy, done, error;

    data_mem_loader #(.MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_BYTES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .startAddr(startAddr), .wordCount(wordCount),
        .byteValid(byteValid), .byteData(byteData), .byteReady(byteReady),
        .coreReadEn(coreReadEn), .coreWriteEn(coreWriteEn), .coreAddress(coreAddress),
        .coreDataIn(coreDataIn), .coreStall(coreStall), .memReadEn(memReadEn),
        .memWriteEn(memWriteEn), .memAddress(memAddress), .memDataIn(memDataIn),
        .memDataOut(memDataOut), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read; one word can be made to store a flipped bit.
    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];
    int          corrupt_word = -1;

    assign memDataOut = mem[memAddress[IW+1:2]];
    always @(posedge clk)
        if (memWriteEn)
            mem[memAddress[IW+1:2]] <= (int'(memAddress[IW+1:2]) == corrupt_word) ?
                                       (memDataIn ^ 32'h1) : memDataIn;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  bytes_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        int mism = 0;
        for (int i = 0; i < NW; i++)
            if (mem[i] !== ref_mem[i]) mism++;
        check(tag, mism, 0);
    endtask

    // One load: the model decides outcome, written words, and (at full rate) latency.
    task automatic run_load(input string name, input logic [31:0] addr, input int cnt,
                            input int valid_pct, input int bad_idx, input bit poke,
                            input bit restart);
        logic [31:0] base;
        longint      end_a;
        bit          range_err, exp_err;
        int          n_written, exp_lat;
        int          bi, cyc, first_ready, done_cyc, done_cnt, wr_cnt, busy_after;
        int          budget;
        logic [31:0] w;

        base      = addr & ~32'h3;
        end_a     = longint'(base) + 4 * cnt;
        range_err = (base < MEM_BASE) || (end_a > MEM_BYTES);
        exp_err   = range_err;
        n_written = range_err ? 0 : cnt;
        if (!range_err && bad_idx >= 0 && bad_idx < cnt) begin
            corrupt_word = int'(base >> 2) + bad_idx;
            exp_err      = 1'b1;
            n_written    = bad_idx + 1;
        end
        while (bytes_q.size() < 4 * cnt) bytes_q.push_back(8'($urandom_range(255)));
        for (int i = 0; i < n_written; i++) begin
            w = {bytes_q[4*i], bytes_q[4*i+1], bytes_q[4*i+2], bytes_q[4*i+3]};
            if (i == bad_idx) w = w ^ 32'h1;
            ref_mem[int'(base >> 2) + i] = w;
        end
        exp_lat = (range_err || cnt == 0) ? 2 : 2 + 6 * n_written;

        @(negedge clk);
        start = 1'b1; startAddr = addr; wordCount = 16'(cnt);
        @(negedge clk);
        start = 1'b0;
        check({name, ":err_clr"}, error, 0);
        cyc = 1; bi = 0; first_ready = -1; done_cyc = -1; done_cnt = 0; wr_cnt = 0; busy_after = -1;
        budget = 100 + 80 * cnt;
        while (cyc < budget) begin
            if (byteReady && first_ready < 0) first_ready = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (memWriteEn) wr_cnt++;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            byteValid = (bi < 4 * cnt) && ($urandom_range(99) < valid_pct);
            byteData  = byteValid ? bytes_q[bi] : 8'($urandom_range(255));
            if (byteReady && byteValid) bi++;
            coreWriteEn = poke && (cyc == 3);
            coreAddress = 32'h500;
            coreDataIn  = 32'hDEADBEEF;
            if (poke && cyc == 3) begin
                #1 check({name, ":stall_busy"}, coreStall, 1);
            end
            if (restart && cyc == 4) begin
                start = 1'b1; startAddr = 32'h600; wordCount = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        byteValid = 1'b0; coreWriteEn = 1'b0; start = 1'b0;

        check({name, ":done_seen"}, done_cyc >= 0, 1);
        check({name, ":done_pulses"}, done_cnt, 1);
        check({name, ":busy_after_done"}, busy_after, 0);
        check({name, ":error"}, error, exp_err);
        check({name, ":writes"}, wr_cnt, n_written);
        check({name, ":ready_seen"}, first_ready >= 0, !range_err && cnt > 0);
        if (valid_pct == 100) begin
            check({name, ":latency"}, done_cyc, exp_lat);
            if (!range_err && cnt > 0) check({name, ":first_ready"}, first_ready, 2);
        end
        check_mem({name, ":mem"});
        corrupt_word = -1;
        bytes_q.delete();
    endtask

    initial begin
        int waited;
        rst = 1'b1; start = 1'b0; startAddr = '0; wordCount = '0;
        byteValid = 1'b0; byteData = '0;
        coreReadEn = 1'b0; coreWriteEn = 1'b0; coreAddress = '0; coreDataIn = '0;
        for (int i = 0; i < NW; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:error", error, 0);
        check("rst:byteReady", byteReady, 0);
        check("rst:coreStall", coreStall, 0);
        check("rst:mem_en", {memReadEn, memWriteEn}, 0);
        check("rst:memAddress", memAddress, 0);
        check("rst:memDataIn", memDataIn, 0);
        rst = 1'b0;

        bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load("basic", 32'h400, 2, 100, -1, 1'b0, 1'b0);
        check("basic:word0", mem[32'h400 >> 2], 32'h11223344);
        check("basic:word1", mem[32'h404 >> 2], 32'h55667788);

        run_load("align", 32'h403, 1, 100, -1, 1'b0, 1'b0);
        run_load("below_base", 32'h3FC, 1, 100, -1, 1'b0, 1'b0);
        run_load("past_top", 32'(MEM_BYTES - 4), 2, 100, -1, 1'b0, 1'b0);
        run_load("exact_top", 32'(MEM_BYTES - 8), 2, 100, -1, 1'b0, 1'b0);
        run_load("zero_len", 32'h400, 0, 100, -1, 1'b0, 1'b0);
        run_load("backpressure", 32'h480, 3, 50, -1, 1'b0, 1'b0);
        run_load("core_mux", 32'h540, 2, 70, -1, 1'b1, 1'b0);
        run_load("start_busy", 32'h420, 2, 100, -1, 1'b0, 1'b1);
        run_load("verify_fail", 32'h580, 3, 100, 1, 1'b0, 1'b0);
        check("sticky_error", error, 1);

        // Core write in IDLE lands in memory without a stall.
        @(negedge clk);
        coreWriteEn = 1'b1; coreAddress = 32'h500; coreDataIn = 32'hCAFEF00D;
        #1 check("idle:stall", coreStall, 0);
        check("idle:mem_we", memWriteEn, 1);
        ref_mem[32'h500 >> 2] = 32'hCAFEF00D;
        @(negedge clk);
        coreWriteEn = 1'b0; coreReadEn = 1'b1;
        #1 check("idle:mem_re", memReadEn, 1);
        check("idle:rdata", memDataOut, 32'hCAFEF00D);
        coreReadEn = 1'b0;
        check_mem("idle:mem");

        // Reset after two bytes of the first word; start in the same cycle loses to rst.
        @(negedge clk);
        start = 1'b1; startAddr = 32'h700; wordCount = 16'd2;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!byteReady && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("midrst:ready_wait", byteReady, 1);
        byteValid = 1'b1; byteData = 8'hAA;
        @(negedge clk);
        byteData = 8'hBB;
        @(negedge clk);
        byteValid = 1'b0; rst = 1'b1; start = 1'b1;
        coreWriteEn = 1'b1; coreAddress = 32'h0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("midrst:busy", busy, 0);
        check("midrst:byteReady", byteReady, 0);
        check("midrst:done", done, 0);
        check("midrst:coreStall", coreStall, 0);
        coreWriteEn = 1'b0;
        check_mem("midrst:mem");
        run_load("after_rst", 32'h700, 2, 100, -1, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++)
            run_load($sformatf("rand%0d", k), 32'($urandom_range(MEM_BASE - 16, MEM_BYTES + 8)),
                     $urandom_range(0, 5), $urandom_range(30, 100), -1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
